rptr_empty_lvl: RTL and testbench
=================================

// Module: rptr_empty_lvl
// PURPOSE
//  Read-side pointer/flag controller for the dual-clock asynchronous FIFO, successor to the basic read-pointer/empty block.
//  Keeps the binary and Gray read pointers, the memory read address and a registered empty flag.
//  Also decodes the synchronised Gray write pointer to produce a registered fill level and an almost-empty flag.
//  Sits entirely in the read clock domain, between the wptr synchroniser and the dual-port RAM read port.
// PARAMETERS
//  ADDRSIZE   6  FIFO depth = 2**ADDRSIZE; pointers are ADDRSIZE+1 bits (extra wrap bit)
//  AE_THRESH  4  ralmost_empty asserts while level <= AE_THRESH; legal range 0..2**ADDRSIZE-1
// PORTS
//  rclk           in   1           read-domain clock
//  rrst           in   1           synchronous, active-high reset
//  rinc           in   1           pop request; honoured only when rempty==0
//  rq2_wptr       in   ADDRSIZE+1  Gray write pointer, already 2-flop synchronised into rclk
//  raddr          out  ADDRSIZE    binary RAM read address = rbin[ADDRSIZE-1:0]
//  rptr           out  ADDRSIZE+1  registered Gray read pointer, to the rptr synchroniser
//  rmem_en        out  1           RAM read enable = rinc & ~rempty (combinational)
//  rempty         out  1           registered empty flag
//  ralmost_empty  out  1           registered almost-empty flag
//  rlevel         out  ADDRSIZE+1  registered occupancy, 0..2**ADDRSIZE, as seen by the read side
//  runderflow     out  1           sticky underflow flag; present only with RPTR_UNDERFLOW_EN
// BEHAVIOUR
//  Reset, rrst=1 at a rclk edge: rbin=0, rptr=0, rempty=1, ralmost_empty=1, rlevel=0, runderflow=0. Reset overrides a simultaneous rinc.
//  A reset mid-stream discards the pointer state; no partial pop completes.
//  Pop: rpop = rinc & ~rempty; rbinnext = rbin + rpop; rgraynext = (rbinnext>>1) ^ rbinnext.
//  Every edge: rbin <= rbinnext and rptr <= rgraynext. Latency: raddr/rptr advance 1 cycle after the accepted pop.
//  rinc while rempty=1: ignored; no pointer movement and no RAM enable.
//  Empty: rempty <= (rgraynext == rq2_wptr), i.e. the flag reflects the post-pop pointer in the same edge.
//  Level: wbin = gray2bin(rq2_wptr); rlevel <= (wbin - rbinnext) mod 2**(ADDRSIZE+1). All arithmetic is unsigned at ADDRSIZE+1 bits.
//  rlevel is pessimistic by the synchroniser delay: it never overstates the contents and never exceeds 2**ADDRSIZE.
//  ralmost_empty <= (level_next <= AE_THRESH). Whenever rempty=1, ralmost_empty=1.
//  Wrap: rbin counts modulo 2**(ADDRSIZE+1). The MSB toggles every 2**ADDRSIZE pops and raddr wraps to 0.
//  Every rptr step changes exactly one bit, including across the wrap.
//  Simultaneous pop and write-pointer advance: both take effect in the same edge; level = wbin - rbinnext, so a net level change of 0 is legal.
//  No state machine: pure counter/comparator pipeline with one register stage on every output except raddr/rmem_en.
// CONFIGURATION
//  RPTR_UNDERFLOW_EN defined: adds output runderflow, which is set on any edge with rinc=1 & rempty=1 and cleared only by rrst.
//  RPTR_UNDERFLOW_EN undefined: the port and its logic are absent; a pop attempt on empty is silently ignored.
// STRUCTURE
//  Shared package fifo_pkg: the bin2gray/gray2bin functions and the width helper PTRW = ADDRSIZE+1.
//  The write-side successor uses the same package.
//  One sub-module: gray2bin_dec #(.W(ADDRSIZE+1)), a combinational XOR-prefix decoder for rq2_wptr.
//  Everything else stays in this module.
//  Elaboration check: AE_THRESH < 2**ADDRSIZE, else $error.
// TESTING (ADDRSIZE=6, AE_THRESH=4 unless stated)
//  1 Reset: hold rrst 2 cycles with rinc=1, rq2_wptr=0x05 -> rempty=1, ralmost_empty=1, rlevel=0, rptr=0, raddr=0.
//    Then release with rq2_wptr=0 -> all outputs unchanged.
//  2 Fill/drain: rq2_wptr=gray(10)=0x0F -> rlevel=10, rempty=0, ralmost_empty=0.
//    Then 10 pops -> ralmost_empty rises when level reaches 4, rempty=1 after the 10th pop, rptr=gray(10), raddr=10.
//  3 Underflow: with rempty=1, pulse rinc for 3 cycles -> rptr/raddr unchanged, rmem_en=0.
//    With RPTR_UNDERFLOW_EN: runderflow=1 and stays 1 until rrst.
//  4 Wrap: stream 200 words with wptr leading rptr by 8 -> raddr sequence 0..63,0..,
//    rptr MSB toggles at pop 64 and 128, single-bit Gray change on every step, rlevel stays 8.
//  5 Full level: rq2_wptr=gray(64)=0x60 from reset -> rlevel=64, ralmost_empty=0.
//    One pop -> rlevel=63 the same cycle, and rempty never asserts.
//  6 Simultaneous: at level 5, pop while rq2_wptr advances by 1 -> rlevel stays 5.
//    Then at level 5 pop with no write -> rlevel=4, ralmost_empty=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared Gray/binary helpers for the async FIFO pointer blocks (read and write side).
// Functions operate on a 32-bit carrier; callers cast the result to their pointer width.
package fifo_pkg;

  localparam int GRAY_CARRIER_W = 32;

  // Pointer width: one extra wrap bit above the address bits.
  function automatic int ptrw(input int addrsize);
    return addrsize + 1;
  endfunction

  function automatic logic [GRAY_CARRIER_W-1:0] bin2gray(input logic [GRAY_CARRIER_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GRAY_CARRIER_W-1:0] gray2bin(input logic [GRAY_CARRIER_W-1:0] g);
    logic [GRAY_CARRIER_W-1:0] b;
    b[GRAY_CARRIER_W-1] = g[GRAY_CARRIER_W-1];
    for (int i = GRAY_CARRIER_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/rptr_empty_lvl_if.sv
// Read-side bundle between the FIFO consumer (master) and rptr_empty_lvl (slave).
// runderflow exists only when RPTR_UNDERFLOW_EN is defined.
interface rptr_empty_lvl_if #(
  parameter int ADDRSIZE = 6
);
  localparam int PTRW = ADDRSIZE + 1;

  // Handshake: a pop happens on a rclk edge where rinc=1 and rempty=0; rinc while
  // rempty=1 is dropped. rmem_en mirrors an accepted pop in the same cycle.
  logic                rinc;
  logic [PTRW-1:0]     rq2_wptr;
  logic [ADDRSIZE-1:0] raddr;
  logic [PTRW-1:0]     rptr;
  logic                rmem_en;
  logic                rempty;
  logic                ralmost_empty;
  logic [PTRW-1:0]     rlevel;
`ifdef RPTR_UNDERFLOW_EN
  logic                runderflow;

  modport master (
    output rinc, rq2_wptr,
    input  raddr, rptr, rmem_en, rempty, ralmost_empty, rlevel, runderflow
  );

  modport slave (
    input  rinc, rq2_wptr,
    output raddr, rptr, rmem_en, rempty, ralmost_empty, rlevel, runderflow
  );
`else
  modport master (
    output rinc, rq2_wptr,
    input  raddr, rptr, rmem_en, rempty, ralmost_empty, rlevel
  );

  modport slave (
    input  rinc, rq2_wptr,
    output raddr, rptr, rmem_en, rempty, ralmost_empty, rlevel
  );
`endif

endinterface

// File: rtl/rptr_empty_lvl_gray2bin_dec.sv
// Combinational Gray-to-binary decoder: each binary bit is the XOR of all Gray bits at or above it.
module gray2bin_dec #(
  parameter int W = 7
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = ^gray[W-1:i];
  end

endmodule

// File: rtl/rptr_empty_lvl.sv
// Read-side pointer/flag controller for the async FIFO: binary/Gray read pointers, empty,
// fill level and almost-empty flags. Optional sticky underflow flag under RPTR_UNDERFLOW_EN.
module rptr_empty_lvl
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE  = 6,
  parameter int AE_THRESH = 4
) (
  input  logic           rclk,
  input  logic           rrst,
  rptr_empty_lvl_if.slave bus
);

  localparam int PTRW = ptrw(ADDRSIZE);
  localparam logic [PTRW-1:0] AE_LIMIT = PTRW'(AE_THRESH);

  if (AE_THRESH < 0 || AE_THRESH >= (1 << ADDRSIZE)) begin : g_bad_thresh
    $error("rptr_empty_lvl: AE_THRESH=%0d out of range 0..%0d", AE_THRESH, (1 << ADDRSIZE) - 1);
  end

  logic [PTRW-1:0] rbin;
  logic [PTRW-1:0] rbin_next;
  logic [PTRW-1:0] rgray_next;
  logic [PTRW-1:0] rptr_q;
  logic [PTRW-1:0] wbin;
  logic [PTRW-1:0] level_next;
  logic [PTRW-1:0] rlevel_q;
  logic            rempty_q;
  logic            ralmost_empty_q;
  logic            rpop;

  gray2bin_dec #(.W(PTRW)) u_wptr_dec (
    .gray (bus.rq2_wptr),
    .bin  (wbin)
  );

  assign rpop       = bus.rinc & ~rempty_q;
  assign rbin_next  = rbin + PTRW'(rpop);
  assign rgray_next = PTRW'(bin2gray(GRAY_CARRIER_W'(rbin_next)));
  // Modular difference stays correct across the wrap bit; never exceeds the depth
  // because the synchronised write pointer can only lag the real one.
  assign level_next = wbin - rbin_next;

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin            <= '0;
      rptr_q          <= '0;
      rempty_q        <= 1'b1;
      ralmost_empty_q <= 1'b1;
      rlevel_q        <= '0;
    end else begin
      rbin            <= rbin_next;
      rptr_q          <= rgray_next;
      rempty_q        <= (rgray_next == bus.rq2_wptr);
      ralmost_empty_q <= (level_next <= AE_LIMIT);
      rlevel_q        <= level_next;
    end
  end

`ifdef RPTR_UNDERFLOW_EN
  logic runderflow_q;

  always_ff @(posedge rclk) begin
    if (rrst) begin
      runderflow_q <= 1'b0;
    end else if (bus.rinc && rempty_q) begin
      runderflow_q <= 1'b1;
    end
  end

  assign bus.runderflow = runderflow_q;
`endif

  assign bus.raddr         = rbin[ADDRSIZE-1:0];
  assign bus.rptr          = rptr_q;
  assign bus.rmem_en       = rpop;
  assign bus.rempty        = rempty_q;
  assign bus.ralmost_empty = ralmost_empty_q;
  assign bus.rlevel        = rlevel_q;

endmodule

// File: tb/tb_rptr_empty_lvl.sv
// Directed + randomized bench for rptr_empty_lvl against a word-count reference model.
module tb_rptr_empty_lvl;

  localparam int ADDRSIZE  = 6;
  localparam int AE_THRESH = 4;
  localparam int DEPTH     = 1 << ADDRSIZE;
  localparam int PTRW      = ADDRSIZE + 1;

  logic clk;
  logic rrst;

  rptr_empty_lvl_if #(.ADDRSIZE(ADDRSIZE)) bus ();

  rptr_empty_lvl #(.ADDRSIZE(ADDRSIZE), .AE_THRESH(AE_THRESH)) dut (
    .rclk (clk),
    .rrst (rrst),
    .bus  (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard counters and reference model: total words written / read as plain integers
  int tests  = 0;
  int failed = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int m_level = 0;
  bit m_empty = 1'b1;
  bit m_uf    = 1'b0;
  logic [PTRW-1:0] prev_ptr;

  function automatic logic [PTRW-1:0] gray(input int n);
    logic [PTRW-1:0] b;
    b = n[PTRW-1:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One rclk cycle: drive inputs, check rmem_en, step the model, check registered outputs
  task automatic cycle(input bit rst, input bit inc, input int wr);
    @(negedge clk);
    rrst         = rst;
    bus.rinc     = inc;
    wr_cnt       = wr;
    bus.rq2_wptr = gray(wr);
    #1;
    chk("rmem_en", 32'(bus.rmem_en), 32'(inc && !m_empty));
    prev_ptr = bus.rptr;
    @(posedge clk);
    #1;
    if (rst) begin
      rd_cnt  = 0;
      m_uf    = 1'b0;
      m_level = 0;
    end else begin
      if (inc && m_empty) m_uf = 1'b1;
      if (inc && !m_empty) rd_cnt++;
      m_level = wr_cnt - rd_cnt;
    end
    m_empty = (m_level == 0);
    chk("rempty", 32'(bus.rempty), 32'(m_empty));
    chk("ralmost_empty", 32'(bus.ralmost_empty), 32'(m_level <= AE_THRESH));
    chk("rlevel", 32'(bus.rlevel), 32'(m_level));
    chk("rptr", 32'(bus.rptr), 32'(gray(rd_cnt)));
    chk("raddr", 32'(bus.raddr), 32'(rd_cnt % DEPTH));
`ifdef RPTR_UNDERFLOW_EN
    chk("runderflow", 32'(bus.runderflow), 32'(m_uf));
`endif
  endtask

  initial begin
    int room;
    int add;
    bit inc;

    rrst         = 1'b1;
    bus.rinc     = 1'b0;
    bus.rq2_wptr = '0;
    @(posedge clk);
    #1;

    // 1 Reset with rinc=1 and rq2_wptr=0x05 (gray(6)), then release with rq2_wptr=0
    cycle(1'b1, 1'b1, 6);
    cycle(1'b1, 1'b1, 6);
    chk("reset_rptr", 32'(bus.rptr), 32'h0);
    cycle(1'b0, 1'b0, 0);
    cycle(1'b0, 1'b0, 0);

    // 2 Fill to 10, drain with 10 pops
    cycle(1'b0, 1'b0, 10);
    chk("fill_level", 32'(bus.rlevel), 32'd10);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 10);
    chk("drain_rptr", 32'(bus.rptr), 32'h0F);
    chk("drain_raddr", 32'(bus.raddr), 32'd10);
    chk("drain_empty", 32'(bus.rempty), 32'd1);

    // 3 Pop attempts on empty
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 10);
    chk("uf_rptr", 32'(bus.rptr), 32'h0F);
`ifdef RPTR_UNDERFLOW_EN
    chk("uf_sticky", 32'(bus.runderflow), 32'd1);
    cycle(1'b0, 1'b0, 10);
    chk("uf_sticky_hold", 32'(bus.runderflow), 32'd1);
`endif

    // 4 Stream 200 words with write pointer leading by 8
    cycle(1'b0, 1'b0, rd_cnt + 8);
    for (int i = 0; i < 200; i++) begin
      cycle(1'b0, 1'b1, wr_cnt + 1);
      chk("wrap_level", 32'(bus.rlevel), 32'd8);
      chk("wrap_onebit", 32'($countones(bus.rptr ^ prev_ptr)), 32'd1);
      chk("wrap_msb", 32'(bus.rptr[PTRW-1]), 32'((rd_cnt / DEPTH) % 2));
    end

    // 5 Full level from reset
    cycle(1'b1, 1'b0, 0);
`ifdef RPTR_UNDERFLOW_EN
    chk("uf_cleared", 32'(bus.runderflow), 32'd0);
`endif
    cycle(1'b0, 1'b0, 64);
    chk("full_level", 32'(bus.rlevel), 32'd64);
    chk("full_ae", 32'(bus.ralmost_empty), 32'd0);
    cycle(1'b0, 1'b1, 64);
    chk("full_pop_level", 32'(bus.rlevel), 32'd63);

    // 6 Simultaneous pop and write at level 5, then a plain pop
    cycle(1'b1, 1'b0, 0);
    cycle(1'b0, 1'b0, 5);
    cycle(1'b0, 1'b1, 6);
    chk("simul_level", 32'(bus.rlevel), 32'd5);
    cycle(1'b0, 1'b1, 6);
    chk("pop_level", 32'(bus.rlevel), 32'd4);
    chk("pop_ae", 32'(bus.ralmost_empty), 32'd1);

    // Randomized traffic with mid-stream reset
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        cycle(1'b1, 1'b1, wr_cnt);
        cycle(1'b0, 1'b0, 0);
      end
      room = DEPTH - (wr_cnt - rd_cnt);
      add  = $urandom_range(0, 3);
      if (add > room) add = room;
      inc  = 1'($urandom_range(0, 1));
      cycle(1'b0, inc, wr_cnt + add);
    end

    // Random fill to full then drain to empty
    while (wr_cnt - rd_cnt < DEPTH) cycle(1'b0, 1'($urandom_range(0, 1)), wr_cnt + 1 + 0);
    while (m_level != 0) cycle(1'b0, 1'b1, wr_cnt);
    chk("final_empty", 32'(bus.rempty), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
